// File: rtl/rtc_mem_pkg.sv
// Shared types and constants for the RTC register-memory scanner.
// The optional alarm comparator is selected with RTC_ALARM_CMP_EN.
package rtc_mem_pkg;

  localparam int NREG_DEFAULT = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_WR,
    ST_COMMIT
  } state_t;

  localparam logic [3:0] ADDR_TIME_SEC    = 4'd0;
  localparam logic [3:0] ADDR_TIME_MIN    = 4'd1;
  localparam logic [3:0] ADDR_TIME_HOUR   = 4'd2;
  localparam logic [3:0] ADDR_TIME_DAY    = 4'd3;
  localparam logic [3:0] ADDR_ALARM_SEC   = 4'd4;
  localparam logic [3:0] ADDR_ALARM_MIN   = 4'd5;
  localparam logic [3:0] ADDR_ALARM_HOUR  = 4'd6;
  localparam logic [3:0] ADDR_ALARM_DAY   = 4'd7;
  localparam logic [3:0] ADDR_CHRONO_SEC  = 4'd8;
  localparam logic [3:0] ADDR_CHRONO_MIN  = 4'd9;
  localparam logic [3:0] ADDR_CHRONO_HOUR = 4'd10;
  localparam logic [3:0] ADDR_STATUS1     = 4'd11;
  localparam logic [3:0] ADDR_STATUS2     = 4'd12;
  localparam logic [3:0] ADDR_STATUS3     = 4'd13;

  localparam logic [7:0] FLAG_COPY_1TO2 = 8'h80;

endpackage

// File: rtl/rtc_mem_scanner_alarm_cmp.sv
// Time/alarm equality comparator gated by the status enable bit.
// Only built when RTC_ALARM_CMP_EN is defined.
`ifdef RTC_ALARM_CMP_EN
module rtc_alarm_cmp (
  input  logic [31:0] time_v,
  input  logic [31:0] alarm_v,
  input  logic        en,
  output logic        hit
);

  assign hit = en && (time_v == alarm_v);

endmodule
`endif

// File: rtl/rtc_mem_scanner.sv
// Port-1 initiator of the dual-bank RTC memory: periodic register scan with
// tear-free snapshots, host writes and bank commits. Alarm compare: RTC_ALARM_CMP_EN.
module rtc_mem_scanner
  import rtc_mem_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr_req,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit_req,
  input  logic [7:0]  mem_q,
  output logic [3:0]  mem_add,
  output logic [7:0]  mem_dat,
  output logic        mem_w,
  output logic        mem_r,
  output logic [7:0]  mem_flags,
  output logic        wr_ack,
  output logic        commit_ack,
  output logic [31:0] time_q,
  output logic [31:0] alarm_q,
  output logic [23:0] chrono_q,
  output logic [23:0] status_q,
  output logic        scan_done,
  output logic        scan_overrun,
  output logic        alarm_hit
);

  state_t                 state;
  logic [3:0]             idx;
  logic                   scan_pend;
  logic [NREG-1:0][7:0]   stage;
  logic [NREG-1:0][7:0]   stage_nx;
  logic [31:0]            stage_time;
  logic [31:0]            stage_alarm;
  logic                   start;
  logic                   last;
  logic                   cmp_hit;

  // Staging as it will look after this cycle's capture, so the last byte
  // lands in the published snapshot on the same edge.
  always_comb begin
    stage_nx      = stage;
    stage_nx[idx] = mem_q;
  end

  assign stage_time  = {stage_nx[ADDR_TIME_DAY], stage_nx[ADDR_TIME_HOUR],
                        stage_nx[ADDR_TIME_MIN], stage_nx[ADDR_TIME_SEC]};
  assign stage_alarm = {stage_nx[ADDR_ALARM_DAY], stage_nx[ADDR_ALARM_HOUR],
                        stage_nx[ADDR_ALARM_MIN], stage_nx[ADDR_ALARM_SEC]};

  // scan_pend holds a request not yet started; it is consumed on leaving IDLE
  // so one tick during a running scan queues exactly one follow-up scan.
  assign start = (state == ST_IDLE) && !wr_req && !commit_req && (scan_pend || tick);
  assign last  = (idx == 4'(NREG - 1));

`ifdef RTC_ALARM_CMP_EN
  rtc_alarm_cmp u_alarm_cmp (
    .time_v  (stage_time),
    .alarm_v (stage_alarm),
    .en      (stage_nx[ADDR_STATUS1][0]),
    .hit     (cmp_hit)
  );
`else
  assign cmp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      scan_pend    <= 1'b0;
      stage        <= '0;
      mem_add      <= '0;
      mem_dat      <= '0;
      mem_w        <= 1'b0;
      mem_r        <= 1'b0;
      mem_flags    <= '0;
      wr_ack       <= 1'b0;
      commit_ack   <= 1'b0;
      time_q       <= '0;
      alarm_q      <= '0;
      chrono_q     <= '0;
      status_q     <= '0;
      scan_done    <= 1'b0;
      scan_overrun <= 1'b0;
      alarm_hit    <= 1'b0;
    end else begin
      mem_w      <= 1'b0;
      mem_r      <= 1'b0;
      mem_flags  <= '0;
      wr_ack     <= 1'b0;
      commit_ack <= 1'b0;
      scan_done  <= 1'b0;
      alarm_hit  <= 1'b0;

      if (tick && scan_pend) scan_overrun <= 1'b1;
      if (start)     scan_pend <= 1'b0;
      else if (tick) scan_pend <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (wr_req) begin
            state   <= ST_WR;
            mem_w   <= 1'b1;
            mem_add <= wr_addr;
            mem_dat <= wr_data;
            wr_ack  <= 1'b1;
          end else if (commit_req) begin
            state      <= ST_COMMIT;
            mem_flags  <= FLAG_COPY_1TO2;
            commit_ack <= 1'b1;
          end else if (start) begin
            state   <= ST_RD_ISSUE;
            idx     <= '0;
            mem_r   <= 1'b1;
            mem_add <= '0;
          end
        end
        ST_RD_ISSUE: state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          stage[idx] <= mem_q;
          if (last) begin
            state     <= ST_IDLE;
            idx       <= '0;
            time_q    <= stage_time;
            alarm_q   <= stage_alarm;
            chrono_q  <= {stage_nx[ADDR_CHRONO_HOUR], stage_nx[ADDR_CHRONO_MIN],
                          stage_nx[ADDR_CHRONO_SEC]};
            status_q  <= {stage_nx[ADDR_STATUS3], stage_nx[ADDR_STATUS2],
                          stage_nx[ADDR_STATUS1]};
            scan_done <= 1'b1;
            alarm_hit <= cmp_hit;
          end else begin
            state   <= ST_RD_ISSUE;
            idx     <= idx + 4'd1;
            mem_r   <= 1'b1;
            mem_add <= idx + 4'd1;
          end
        end
        ST_WR:     state <= ST_IDLE;
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
